// File: rtl/controlador_display_7seg.sv
// Load/convert/capture sequencer for the binary-to-BCD converter plus a multiplexed
// common-anode 7-segment driver. Define BLANCO_CEROS_EN to blank leading zero digits.
module controlador_display_7seg #(
  parameter int TAM_REG_BIN  = 8,
  parameter int N_DIG        = 3,
  parameter int DIV_REFRESCO = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TAM_REG_BIN-1:0] dato_bin,
  input  logic                   dato_valido,
  output logic                   dato_listo,
  output logic [TAM_REG_BIN-1:0] bin_conv,
  input  logic [TAM_REG_BIN+3:0] bcd_conv,
  output logic [N_DIG-1:0]       anodos,
  output logic [6:0]             segmentos,
  output logic                   ocupado
);

  localparam int CNT_W = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int BCD_W = TAM_REG_BIN + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_REFRESCO - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIG - 1);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    CONV   = 2'd1,
    CAPT   = 2'd2
  } estado_t;

  estado_t                estado_r;
  logic [TAM_REG_BIN-1:0] bin_conv_r;
  logic [BCD_W-1:0]       bcd_reg_r;
  logic                   dato_listo_r;
  logic                   ocupado_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [IDX_W-1:0]       idx_r;
  logic [IDX_W-1:0]       idx_next_s;
  logic                   fin_cnt_s;
  logic [N_DIG-1:0]       anodos_r;
  logic [N_DIG-1:0]       anodos_s;
  logic [6:0]             seg_r;
  logic [6:0]             seg_s;
  logic [3:0]             nibble_s;
  logic                   blanco_s;
`ifdef BLANCO_CEROS_EN
  logic                   hay_cifra_s;
`endif

  // Active-low segment pattern {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash
  function automatic logic [6:0] decod_7seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase
    return seg;
  endfunction

  // Load FSM: accept operand, give the converter one settle cycle, then capture
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r     <= REPOSO;
      bin_conv_r   <= '0;
      bcd_reg_r    <= '0;
      dato_listo_r <= 1'b0;
      ocupado_r    <= 1'b0;
    end else begin
      case (estado_r)
        REPOSO: begin
          if (dato_valido && dato_listo_r) begin
            bin_conv_r   <= dato_bin;
            estado_r     <= CONV;
            dato_listo_r <= 1'b0;
            ocupado_r    <= 1'b1;
          end else begin
            dato_listo_r <= 1'b1;
            ocupado_r    <= 1'b0;
          end
        end
        CONV: begin
          estado_r     <= CAPT;
          dato_listo_r <= 1'b0;
          ocupado_r    <= 1'b1;
        end
        CAPT: begin
          bcd_reg_r    <= bcd_conv;
          estado_r     <= REPOSO;
          dato_listo_r <= 1'b1;
          ocupado_r    <= 1'b0;
        end
        default: begin
          estado_r     <= REPOSO;
          dato_listo_r <= 1'b0;
          ocupado_r    <= 1'b0;
        end
      endcase
    end
  end

  // Next digit selection, anode pattern and segment pattern for that digit
  always_comb begin
    fin_cnt_s  = (cnt_r == CNT_MAX);
    idx_next_s = idx_r;
    if (fin_cnt_s) begin
      if (idx_r == IDX_MAX) begin
        idx_next_s = '0;
      end else begin
        idx_next_s = idx_r + IDX_W'(1);
      end
    end else begin
      idx_next_s = idx_r;
    end

    nibble_s = 4'h0;
    anodos_s = '1;
    for (int k = 0; k < N_DIG; k++) begin
      if (k == int'(idx_next_s)) begin
        nibble_s    = bcd_reg_r[k*4 +: 4];
        anodos_s[k] = 1'b0;
      end else begin
        anodos_s[k] = 1'b1;
      end
    end

`ifdef BLANCO_CEROS_EN
    // A digit is blank when it and every more significant digit are zero
    hay_cifra_s = 1'b0;
    for (int k = 0; k < N_DIG; k++) begin
      if ((k >= int'(idx_next_s)) && (bcd_reg_r[k*4 +: 4] != 4'h0)) begin
        hay_cifra_s = 1'b1;
      end else begin
        hay_cifra_s = hay_cifra_s;
      end
    end
    blanco_s = (idx_next_s != '0) && !hay_cifra_s;
`else
    blanco_s = 1'b0;
`endif

    if (blanco_s) begin
      seg_s = 7'h7F;
    end else begin
      seg_s = decod_7seg(nibble_s);
    end
  end

  // Free-running scan; anodes and segments switch on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= '0;
      idx_r    <= '0;
      anodos_r <= '1;
      seg_r    <= 7'h7F;
    end else begin
      cnt_r    <= fin_cnt_s ? '0 : cnt_r + CNT_W'(1);
      idx_r    <= idx_next_s;
      anodos_r <= anodos_s;
      seg_r    <= seg_s;
    end
  end

  assign dato_listo = dato_listo_r;
  assign ocupado    = ocupado_r;
  assign bin_conv   = bin_conv_r;
  assign anodos     = anodos_r;
  assign segmentos  = seg_r;

endmodule

// File: tb/tb_controlador_display_7seg.sv
// Directed bench for controlador_display_7seg with a behavioural binary-to-BCD stub
// that can be overridden to inject illegal BCD nibbles.
module tb_controlador_display_7seg;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  dato_bin;
  logic        dato_valido;
  logic        dato_listo;
  logic [7:0]  bin_conv;
  logic [11:0] bcd_conv;
  logic [2:0]  anodos;
  logic [6:0]  segmentos;
  logic        ocupado;
  logic        force_en;
  logic [11:0] force_val;

  int total = 0;
  int bad   = 0;

`ifdef BLANCO_CEROS_EN
  localparam logic [6:0] SEG_CERO_ALTO = 7'h7F;
`else
  localparam logic [6:0] SEG_CERO_ALTO = 7'h40;
`endif

  controlador_display_7seg #(
    .TAM_REG_BIN (8),
    .N_DIG       (3),
    .DIV_REFRESCO(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dato_bin   (dato_bin),
    .dato_valido(dato_valido),
    .dato_listo (dato_listo),
    .bin_conv   (bin_conv),
    .bcd_conv   (bcd_conv),
    .anodos     (anodos),
    .segmentos  (segmentos),
    .ocupado    (ocupado)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] bin2bcd(input logic [7:0] v);
    int h, t, u;
    h = int'(v) / 100;
    t = (int'(v) / 10) % 10;
    u = int'(v) % 10;
    return {h[3:0], t[3:0], u[3:0]};
  endfunction

  assign bcd_conv = force_en ? force_val : bin2bcd(bin_conv);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_digit(input int d, input logic [6:0] seg_exp, input string tag);
    logic [2:0] pat;
    pat = ~(3'b001 << d);
    tick();
    for (int i = 0; i < 16 && anodos !== pat; i++) tick();
    chk({tag, "_an"}, 32'(anodos), 32'(pat));
    chk(tag, 32'(segmentos), 32'(seg_exp));
  endtask

  task automatic send(input logic [7:0] v);
    dato_bin    = v;
    dato_valido = 1'b1;
    tick();
    dato_valido = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    dato_bin    = 8'd0;
    dato_valido = 1'b0;
    force_en    = 1'b0;
    force_val   = 12'h000;

    // Reset held for three cycles
    tick(); tick(); tick();
    chk("rst_anodos", 32'(anodos), 32'(3'b111));
    chk("rst_seg", 32'(segmentos), 32'(7'h7F));
    chk("rst_listo", 32'(dato_listo), 32'(1'b0));
    chk("rst_ocupado", 32'(ocupado), 32'(1'b0));

    // Scan sequence after release: 4 cycles per digit, 110 -> 101 -> 011 -> 110
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      logic [2:0] exp_an;
      tick();
      exp_an = ~(3'b001 << ((k / 4) % 3));
      chk("scan_an", 32'(anodos), 32'(exp_an));
    end
    chk("idle_listo", 32'(dato_listo), 32'(1'b1));
    chk("idle_ocupado", 32'(ocupado), 32'(1'b0));

    // 255: one-cycle valid, two busy cycles
    dato_bin    = 8'd255;
    dato_valido = 1'b1;
    tick();
    dato_valido = 1'b0;
    chk("t255_bin", 32'(bin_conv), 32'(8'd255));
    chk("t255_oc1", 32'(ocupado), 32'(1'b1));
    chk("t255_rdy1", 32'(dato_listo), 32'(1'b0));
    tick();
    chk("t255_oc2", 32'(ocupado), 32'(1'b1));
    tick();
    chk("t255_oc3", 32'(ocupado), 32'(1'b0));
    chk("t255_rdy3", 32'(dato_listo), 32'(1'b1));
    wait_digit(0, 7'h12, "t255_u");
    wait_digit(1, 7'h12, "t255_t");
    wait_digit(2, 7'h24, "t255_h");

    // Valid held while busy: 200 accepted, 17 only at T+3
    dato_bin    = 8'd200;
    dato_valido = 1'b1;
    tick();
    chk("hold_bin1", 32'(bin_conv), 32'(8'd200));
    chk("hold_rdy1", 32'(dato_listo), 32'(1'b0));
    dato_bin = 8'd17;
    tick();
    chk("hold_bin2", 32'(bin_conv), 32'(8'd200));
    chk("hold_rdy2", 32'(dato_listo), 32'(1'b0));
    tick();
    chk("hold_bin3", 32'(bin_conv), 32'(8'd200));
    chk("hold_rdy3", 32'(dato_listo), 32'(1'b1));
    tick();
    dato_valido = 1'b0;
    chk("hold_bin4", 32'(bin_conv), 32'(8'd17));
    chk("hold_oc4", 32'(ocupado), 32'(1'b1));
    tick(); tick();
    wait_digit(0, 7'h78, "t17_u");
    wait_digit(1, 7'h79, "t17_t");
    wait_digit(2, SEG_CERO_ALTO, "t17_h");

    // Leading zeros for 7
    send(8'd7);
    wait_digit(0, 7'h78, "t7_u");
    wait_digit(1, SEG_CERO_ALTO, "t7_t");
    wait_digit(2, SEG_CERO_ALTO, "t7_h");

    // Illegal BCD nibble from the converter stub, then the 2->0 wrap
    force_en  = 1'b1;
    force_val = 12'h1B5;
    send(8'd0);
    force_en = 1'b0;
    wait_digit(0, 7'h12, "ilg_u");
    wait_digit(1, 7'h3F, "ilg_t");
    wait_digit(2, 7'h79, "ilg_h");
    for (int i = 0; i < 8 && anodos === 3'b011; i++) tick();
    chk("wrap_an", 32'(anodos), 32'(3'b110));

    // Reset while in CONV drops the pending value
    dato_bin    = 8'd99;
    dato_valido = 1'b1;
    tick();
    dato_valido = 1'b0;
    chk("mid_oc", 32'(ocupado), 32'(1'b1));
    reset = 1'b1;
    tick();
    chk("mid_rst_an", 32'(anodos), 32'(3'b111));
    chk("mid_rst_seg", 32'(segmentos), 32'(7'h7F));
    chk("mid_rst_oc", 32'(ocupado), 32'(1'b0));
    chk("mid_rst_bin", 32'(bin_conv), 32'(8'd0));
    reset = 1'b0;
    tick();
    chk("mid_rel_an", 32'(anodos), 32'(3'b110));
    chk("mid_rel_seg", 32'(segmentos), 32'(7'h40));
    chk("mid_rel_rdy", 32'(dato_listo), 32'(1'b1));
    tick(); tick(); tick();
    wait_digit(0, 7'h40, "mid_u");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
